muldiv_unit: RTL and testbench

- Iterative multiply/divide unit for the pipelined MIPS core. It sits beside the ALU in EX and owns the HI/LO registers.
- Executes MULT, MULTU, DIV and DIVU over multiple cycles using shift-add and restoring division. Holds `busy` so the hazard unit can stall.
- Serves MTHI/MTLO writes and MFHI/MFLO reads.
- The ALU keeps all single-cycle operations. This block handles the long-latency operations the ALU cannot.

---
 rtl/muldiv_pkg.sv | 28 ++
 rtl/muldiv_if.sv | 31 +++
 rtl/muldiv_step.sv | 52 +++++
 rtl/muldiv_unit.sv | 147 ++++++++++++++
 tb/tb_muldiv_unit.sv | 198 +++++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared definitions for the iterative multiply/divide unit.
//   XLEN            operand width; HI and LO are each XLEN bits
//   OP_*            operation encodings carried on the op port
//   S_*             FSM state encodings
//   is_signed_op()  true for MULT and DIV
//   is_div_op()     true for DIV and DIVU
package muldiv_pkg;

  localparam int XLEN = 32;

  localparam logic [1:0] OP_MULT  = 2'b00;
  localparam logic [1:0] OP_MULTU = 2'b01;
  localparam logic [1:0] OP_DIV   = 2'b10;
  localparam logic [1:0] OP_DIVU  = 2'b11;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_FIX  = 2'd2;

  function automatic logic is_signed_op(input logic [1:0] op);
    return (op == OP_MULT) || (op == OP_DIV);
  endfunction

  function automatic logic is_div_op(input logic [1:0] op);
    return !((op == OP_MULT) || (op == OP_MULTU));
  endfunction

endpackage

// File: rtl/muldiv_if.sv
// Request/result bundle between the EX stage and the multiply/divide unit.
//   start, op, A, B      operation request (op: MULT/MULTU/DIV/DIVU)
//   mthi, mtlo, wdata    direct writes to HI / LO
//   busy, done           in-flight flag and one-cycle completion pulse
//   HI, LO               architectural HI/LO registers
// master: the pipeline side; slave: the muldiv_unit side.
interface muldiv_if #(
  parameter int XLEN = muldiv_pkg::XLEN
);
  logic            start;
  logic [1:0]      op;
  logic [XLEN-1:0] A;
  logic [XLEN-1:0] B;
  logic            mthi;
  logic            mtlo;
  logic [XLEN-1:0] wdata;
  logic            busy;
  logic            done;
  logic [XLEN-1:0] HI;
  logic [XLEN-1:0] LO;

  modport master (
    output start, op, A, B, mthi, mtlo, wdata,
    input  busy, done, HI, LO
  );

  modport slave (
    input  start, op, A, B, mthi, mtlo, wdata,
    output busy, done, HI, LO
  );
endinterface

// File: rtl/muldiv_step.sv
// One iteration of the shift-add multiplier / restoring divider.
//   is_div            1: divide step, 0: multiply step
//   hi, lo            current accumulator halves
//                     multiply: hi = partial product, lo = remaining multiplier bits
//                     divide:   hi = partial remainder, lo = dividend / quotient bits
//   operand           multiplicand (multiply) or divisor (divide) magnitude
//   hi_next, lo_next  accumulator after this iteration
module muldiv_step #(
  parameter int XLEN = 32
) (
  input  logic            is_div,
  input  logic [XLEN-1:0] hi,
  input  logic [XLEN-1:0] lo,
  input  logic [XLEN-1:0] operand,
  output logic [XLEN-1:0] hi_next,
  output logic [XLEN-1:0] lo_next
);

  logic [XLEN:0] sum;
  logic [XLEN:0] shifted;
  logic [XLEN:0] diff;

  // NOTE: every output of a combinational block gets a default first, so no
  // path leaves it unassigned and no latch is inferred.
  always_comb begin
    sum     = '0;
    shifted = '0;
    diff    = '0;
    hi_next = hi;
    lo_next = lo;
    if (is_div) begin
      // Shift the next dividend bit into the remainder, then trial-subtract.
      // A clear borrow bit means the divisor fits and the quotient bit is 1.
      shifted = {hi, lo[XLEN-1]};
      diff    = shifted - {1'b0, operand};
      if (diff[XLEN]) begin
        hi_next = shifted[XLEN-1:0];
        lo_next = {lo[XLEN-2:0], 1'b0};
      end else begin
        hi_next = diff[XLEN-1:0];
        lo_next = {lo[XLEN-2:0], 1'b1};
      end
    end else begin
      // Add the multiplicand when the multiplier LSB is set, then shift the
      // whole {carry, hi, lo} right; the carry becomes the new hi MSB.
      sum     = {1'b0, hi} + (lo[0] ? {1'b0, operand} : '0);
      hi_next = sum[XLEN:1];
      lo_next = {sum[0], lo[XLEN-1:1]};
    end
  end

endmodule

// File: rtl/muldiv_unit.sv
// Iterative multiply/divide unit owning the HI/LO registers.
// Executes MULT/MULTU/DIV/DIVU in ITER iterations on operand magnitudes, then
// applies sign correction; serves MTHI/MTLO writes while idle.
//   clk    system clock
//   reset  synchronous active-high reset; aborts any operation in flight
//   bus    muldiv_if slave: start/op/A/B request, mthi/mtlo/wdata writes,
//          busy/done status, HI/LO results
// Timing with start in cycle 0: busy in cycles 1..ITER+1, done and new HI/LO
// in cycle ITER+2. Divide by zero skips the iterations (done in cycle 2).
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int XLEN = muldiv_pkg::XLEN,
  parameter int ITER = XLEN   // must equal XLEN: one iteration per operand bit
) (
  input  logic     clk,
  input  logic     reset,
  muldiv_if.slave  bus
);

  localparam int CW = $clog2(ITER);

  logic [1:0]        state;
  logic [CW-1:0]     count;
  logic [XLEN-1:0]   acc_hi;
  logic [XLEN-1:0]   acc_lo;
  logic [XLEN-1:0]   operand;
  logic              is_div;
  logic              neg_res;   // negate product / quotient
  logic              neg_rem;   // negate remainder
  logic [XLEN-1:0]   hi_q;
  logic [XLEN-1:0]   lo_q;
  logic              done_q;

  // Request decode, used only when a start is accepted in IDLE.
  logic              start_signed;
  logic              start_div;
  logic              sign_a;
  logic              sign_b;
  logic              div_zero;
  logic [XLEN-1:0]   mag_a;
  logic [XLEN-1:0]   mag_b;

  assign start_signed = is_signed_op(bus.op);
  assign start_div    = is_div_op(bus.op);
  assign sign_a       = start_signed & bus.A[XLEN-1];
  assign sign_b       = start_signed & bus.B[XLEN-1];
  assign mag_a        = sign_a ? -bus.A : bus.A;
  assign mag_b        = sign_b ? -bus.B : bus.B;
  assign div_zero     = start_div && (bus.B == '0);

  logic [XLEN-1:0] step_hi;
  logic [XLEN-1:0] step_lo;

  muldiv_step #(.XLEN(XLEN)) u_step (
    .is_div  (is_div),
    .hi      (acc_hi),
    .lo      (acc_lo),
    .operand (operand),
    .hi_next (step_hi),
    .lo_next (step_lo)
  );

  // Sign fixup applied in FIX. The 0x80000000 / -1 quotient wraps back to
  // 0x80000000 through the same negation, which is the defined result.
  logic [2*XLEN-1:0] neg_product;
  logic [XLEN-1:0]   fix_hi;
  logic [XLEN-1:0]   fix_lo;

  assign neg_product = -{acc_hi, acc_lo};

  always_comb begin
    fix_hi = acc_hi;
    fix_lo = acc_lo;
    if (is_div) begin
      if (neg_res) fix_lo = -acc_lo;
      if (neg_rem) fix_hi = -acc_hi;
    end else if (neg_res) begin
      {fix_hi, fix_lo} = neg_product;
    end
  end

  // NOTE: sequential state is written only with non-blocking assignments so
  // every register samples the pre-edge values regardless of statement order.
  always_ff @(posedge clk) begin
    if (reset) begin
      state   <= S_IDLE;
      count   <= '0;
      acc_hi  <= '0;
      acc_lo  <= '0;
      operand <= '0;
      is_div  <= 1'b0;
      neg_res <= 1'b0;
      neg_rem <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      done_q  <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state)
        S_IDLE: begin
          if (bus.mthi) hi_q <= bus.wdata;
          if (bus.mtlo) lo_q <= bus.wdata;
          if (bus.start) begin
            is_div <= start_div;
            count  <= '0;
            if (div_zero) begin
              // Result is fixed: quotient all ones, remainder = raw dividend.
              acc_hi  <= bus.A;
              acc_lo  <= '1;
              operand <= '0;
              neg_res <= 1'b0;
              neg_rem <= 1'b0;
              state   <= S_FIX;
            end else begin
              acc_hi  <= '0;
              acc_lo  <= start_div ? mag_a : mag_b;
              operand <= start_div ? mag_b : mag_a;
              neg_res <= sign_a ^ sign_b;
              neg_rem <= start_div & sign_a;
              state   <= S_RUN;
            end
          end
        end
        S_RUN: begin
          acc_hi <= step_hi;
          acc_lo <= step_lo;
          count  <= count + 1'b1;
          if (count == CW'(ITER - 1)) state <= S_FIX;
        end
        S_FIX: begin
          hi_q   <= fix_hi;
          lo_q   <= fix_lo;
          done_q <= 1'b1;
          state  <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign bus.busy = (state != S_IDLE);
  assign bus.done = done_q;
  assign bus.HI   = hi_q;
  assign bus.LO   = lo_q;

endmodule

// File: tb/tb_muldiv_unit.sv
// Self-checking bench for muldiv_unit: directed operations with hand-computed
// HI/LO/latency literals, plus a cycle-by-cycle comparison of busy/done/HI/LO
// against an arithmetic reference model (countdown + SV integer arithmetic).
module tb_muldiv_unit;
  import muldiv_pkg::*;

  logic clk;
  logic reset;
  int   total;
  int   bad;
  logic cmp_en;

  muldiv_if bus ();

  muldiv_unit dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference result {HI, LO} computed directly from the operation's meaning.
  function automatic logic [63:0] ref_result(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] res;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    case (o)
      OP_MULT:  res = 64'(sa * sb);
      OP_MULTU: res = {32'h0, a} * {32'h0, b};
      OP_DIV: begin
        if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
        else begin
          q = sa / sb;
          r = sa % sb;
          res = {r[31:0], q[31:0]};
        end
      end
      default: begin
        if (b == 32'h0) res = {a, 32'hFFFF_FFFF};
        else res = {a % b, a / b};
      end
    endcase
    return res;
  endfunction

  // Reference model: m_rem counts remaining busy cycles; zero means idle.
  logic [31:0] m_hi, m_lo;
  logic        m_done;
  int          m_rem;
  logic [63:0] m_pend;

  initial begin
    m_hi = '0; m_lo = '0; m_done = 1'b0; m_rem = 0; m_pend = '0;
    forever begin
      @(posedge clk);
      if (reset) begin
        m_hi = '0; m_lo = '0; m_done = 1'b0; m_rem = 0;
      end else begin
        m_done = 1'b0;
        if (m_rem == 0) begin
          if (bus.mthi) m_hi = bus.wdata;
          if (bus.mtlo) m_lo = bus.wdata;
          if (bus.start) begin
            m_pend = ref_result(bus.op, bus.A, bus.B);
            m_rem  = (bus.op[1] && bus.B == 32'h0) ? 1 : 33;
          end
        end else begin
          m_rem--;
          if (m_rem == 0) begin
            {m_hi, m_lo} = m_pend;
            m_done = 1'b1;
          end
        end
      end
    end
  end

  // Compare process: outputs sampled on the falling edge, every cycle.
  initial begin
    forever begin
      @(negedge clk);
      if (cmp_en) begin
        check("cyc_busy", 64'(bus.busy), 64'(m_rem != 0));
        check("cyc_done", 64'(bus.done), 64'(m_done));
        check("cyc_hi", 64'(bus.HI), 64'(m_hi));
        check("cyc_lo", 64'(bus.LO), 64'(m_lo));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Call at posedge+1 (cycle 0). Optionally writes LO alongside start, and
  // optionally pokes start+mtlo during cycle `poke` while busy.
  task automatic run_op(input string name, input logic [1:0] o, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] hi_e, input logic [31:0] lo_e,
                        input int lat, input int poke, input logic wr_lo, input logic [31:0] wval);
    int n;
    bus.start = 1'b1; bus.op = o; bus.A = a; bus.B = b;
    bus.mtlo = wr_lo; bus.wdata = wval;
    @(posedge clk); #1;
    bus.start = 1'b0; bus.mtlo = 1'b0;
    n = 1;
    check({name, "_busy1"}, 64'(bus.busy), 64'd1);
    if (wr_lo) check({name, "_wlo"}, 64'(bus.LO), 64'(wval));
    while (bus.done !== 1'b1 && n < 40) begin
      if (n == poke) begin
        bus.start = 1'b1; bus.mtlo = 1'b1; bus.op = OP_DIVU;
        bus.A = 32'h1; bus.B = 32'h0; bus.wdata = 32'hDEAD_BEEF;
      end
      @(posedge clk); #1;
      bus.start = 1'b0; bus.mtlo = 1'b0;
      n++;
    end
    check({name, "_latency"}, 64'(n), 64'(lat));
    check({name, "_hi"}, 64'(bus.HI), 64'(hi_e));
    check({name, "_lo"}, 64'(bus.LO), 64'(lo_e));
    check({name, "_idle"}, 64'(bus.busy), 64'd0);
  endtask

  initial begin
    total = 0; bad = 0; cmp_en = 1'b0;
    reset = 1'b1;
    bus.start = 1'b0; bus.op = '0; bus.A = '0; bus.B = '0;
    bus.mthi = 1'b0; bus.mtlo = 1'b0; bus.wdata = '0;
    @(posedge clk); #1;
    cmp_en = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("rst_busy", 64'(bus.busy), 64'd0);
    check("rst_done", 64'(bus.done), 64'd0);
    check("rst_hi", 64'(bus.HI), 64'd0);
    check("rst_lo", 64'(bus.LO), 64'd0);

    // MTHI / MTLO in IDLE take effect at the next edge.
    bus.mthi = 1'b1; bus.wdata = 32'h0000_00AA;
    @(posedge clk); #1;
    bus.mthi = 1'b0;
    check("mthi_hi", 64'(bus.HI), 64'h0000_00AA);
    check("mthi_lo", 64'(bus.LO), 64'd0);
    bus.mtlo = 1'b1; bus.wdata = 32'h1234_5678;
    @(posedge clk); #1;
    bus.mtlo = 1'b0;
    check("mtlo_lo", 64'(bus.LO), 64'h1234_5678);
    check("mtlo_hi", 64'(bus.HI), 64'h0000_00AA);

    run_op("mult_neg",  OP_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 34, 0, 1'b0, '0);
    run_op("multu_max", OP_MULTU, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 32'h0000_0001, 34, 0, 1'b0, '0);
    run_op("div_neg",   OP_DIV,   32'hFFFF_FFF9, 32'd2,        32'hFFFF_FFFF, 32'hFFFF_FFFD, 34, 0, 1'b0, '0);
    run_op("divu",      OP_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        34, 0, 1'b0, '0);
    run_op("div_ovf",   OP_DIV,   32'h8000_0000, 32'hFFFF_FFFF, 32'h0,        32'h8000_0000, 34, 0, 1'b0, '0);
    run_op("divu_z",    OP_DIVU,  32'h0000_1234, 32'h0,        32'h0000_1234, 32'hFFFF_FFFF, 2,  0, 1'b0, '0);
    run_op("div_z",     OP_DIV,   32'hFFFF_FFF0, 32'h0,        32'hFFFF_FFF0, 32'hFFFF_FFFF, 2,  0, 1'b0, '0);
    run_op("mult_mix",  OP_MULT,  32'h0001_0000, 32'hFFFF_0000, 32'hFFFF_FFFF, 32'h0000_0000, 34, 0, 1'b0, '0);
    // start + mtlo while busy in cycle 10 are both ignored.
    run_op("mult_poke", OP_MULT,  32'hFFFF_FFFD, 32'd5,        32'hFFFF_FFFF, 32'hFFFF_FFF1, 34, 10, 1'b0, '0);
    // mtlo with start in IDLE: write lands, then the result overwrites it.
    run_op("wlo_start", OP_DIVU,  32'd100,       32'd7,        32'd2,         32'd14,        34, 0, 1'b1, 32'h0000_0055);

    // Reset in cycle 20 of a MULT aborts it; no done, HI/LO cleared.
    bus.start = 1'b1; bus.op = OP_MULT; bus.A = 32'd7; bus.B = 32'd9;
    @(posedge clk); #1;
    bus.start = 1'b0;
    for (int i = 1; i < 20; i++) begin
      @(posedge clk); #1;
    end
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    check("abort_busy", 64'(bus.busy), 64'd0);
    check("abort_hi", 64'(bus.HI), 64'd0);
    check("abort_lo", 64'(bus.LO), 64'd0);
    for (int i = 0; i < 40; i++) begin
      check("abort_nodone", 64'(bus.done), 64'd0);
      @(posedge clk); #1;
    end
    check("abort_hold_lo", 64'(bus.LO), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
